// File: rtl/elem_rr_arbiter.sv
// Round-robin arbiter with bounded-burst lock: N valid/ready requesters share one
// registered element stream output, each element tagged with its source index.
module elem_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ELEM_WIDTH = 4,
  parameter int BURST      = 1,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic [NUM_REQ-1:0]            req_en_i,
  input  logic [NUM_REQ*ELEM_WIDTH-1:0] elem_in_i,
  input  logic [NUM_REQ-1:0]            elem_in_valid_i,
  output logic [NUM_REQ-1:0]            elem_in_ready_o,
  output logic [ELEM_WIDTH-1:0]         elem_out_o,
  output logic [IDW-1:0]                elem_out_id_o,
  output logic                          elem_out_valid_o,
  input  logic                          elem_out_ready_i
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  logic                  vld_p1;
  logic [ELEM_WIDTH-1:0] data_p1;
  logic [IDW-1:0]        id_p1;
  logic [IDW-1:0]        owner;
  logic                  locked;
  logic [CW-1:0]         cnt;

  logic                  load;
  logic [NUM_REQ-1:0]    elig;
  logic                  keep;
  logic                  win_vld;
  logic [IDW-1:0]        winner;
  logic [ELEM_WIDTH-1:0] win_data;

  // Stage p0: winner selection and combinational ready
  always_comb begin
    load    = !vld_p1 || elem_out_ready_i;
    elig    = elem_in_valid_i & req_en_i;
    keep    = locked && elig[owner] && (cnt < BURST_C);
    win_vld = 1'b0;
    winner  = owner;
    if (keep) begin
      win_vld = 1'b1;
    end else begin
      // Rotating search starts just past the last owner and wraps back to it.
      for (int i = 1; i <= NUM_REQ; i++) begin
        if (!win_vld && elig[(int'(owner) + i) % NUM_REQ]) begin
          win_vld = 1'b1;
          winner  = IDW'((int'(owner) + i) % NUM_REQ);
        end
      end
    end
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == IDW'(k)) win_data = elem_in_i[k*ELEM_WIDTH +: ELEM_WIDTH];
    end
    elem_in_ready_o = '0;
    if (arst_ni && load && win_vld) elem_in_ready_o[winner] = 1'b1;
  end

  // Stage p1: output register and arbitration state
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      id_p1   <= '0;
      owner   <= IDW'(NUM_REQ - 1);
      locked  <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      if (win_vld) begin
        vld_p1  <= 1'b1;
        data_p1 <= win_data;
        id_p1   <= winner;
        if (keep) begin
          cnt <= cnt + CW'(1);
        end else begin
          owner  <= winner;
          cnt    <= CW'(1);
          locked <= 1'b1;
        end
      end else begin
        vld_p1 <= 1'b0;
        locked <= 1'b0;
      end
    end
  end

  assign elem_out_o       = data_p1;
  assign elem_out_id_o    = id_p1;
  assign elem_out_valid_o = vld_p1;

endmodule

// File: tb/tb_elem_rr_arbiter.sv
// Bench for elem_rr_arbiter: BURST=1 and BURST=2 instances share directed stimulus
// and are checked every cycle against a distance-based arbitration model.
module tb_elem_rr_arbiter;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           arst_ni;
  logic [N-1:0]   req_en;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] elem_in;
  logic           out_ready;

  logic [N-1:0]   rdy [2];
  logic [W-1:0]   od  [2];
  logic [IDW-1:0] oid [2];
  logic           ov  [2];

  elem_rr_arbiter #(.NUM_REQ(N), .ELEM_WIDTH(W), .BURST(1)) u_b1 (
    .clk_i(clk), .arst_ni(arst_ni), .req_en_i(req_en), .elem_in_i(elem_in),
    .elem_in_valid_i(in_valid), .elem_in_ready_o(rdy[0]), .elem_out_o(od[0]),
    .elem_out_id_o(oid[0]), .elem_out_valid_o(ov[0]), .elem_out_ready_i(out_ready)
  );

  elem_rr_arbiter #(.NUM_REQ(N), .ELEM_WIDTH(W), .BURST(2)) u_b2 (
    .clk_i(clk), .arst_ni(arst_ni), .req_en_i(req_en), .elem_in_i(elem_in),
    .elem_in_valid_i(in_valid), .elem_in_ready_o(rdy[1]), .elem_out_o(od[1]),
    .elem_out_id_o(oid[1]), .elem_out_valid_o(ov[1]), .elem_out_ready_i(out_ready)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(string name, int m, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, m, act, exp, $time);
    end
  endtask

  // Model: owner, length of the current run, whether a run is active, output reg.
  int burst_of [2] = '{1, 2};
  int m_owner  [2] = '{3, 3};
  int m_run    [2] = '{0, 0};
  bit m_lock   [2] = '{0, 0};
  bit m_ov     [2] = '{0, 0};
  int m_od     [2] = '{0, 0};
  int m_oid    [2] = '{0, 0};
  int n_owner  [2] = '{3, 3};
  int n_run    [2] = '{0, 0};
  bit n_lock   [2] = '{0, 0};
  bit n_ov     [2] = '{0, 0};
  int n_od     [2] = '{0, 0};
  int n_oid    [2] = '{0, 0};

  int glog0 [$];
  int glog1 [$];

  logic [N-1:0] e;
  int win, bestd, d;
  bit ld;

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      check("out_valid", m, ov[m], m_ov[m]);
      check("out_data", m, od[m], m_od[m]);
      check("out_id", m, oid[m], m_oid[m]);
      e   = in_valid & req_en;
      ld  = !m_ov[m] || out_ready;
      win = -1;
      if (arst_ni && ld) begin
        if (m_lock[m] && e[m_owner[m]] && m_run[m] < burst_of[m]) begin
          win = m_owner[m];
        end else begin
          bestd = N;
          for (int k = 0; k < N; k++) begin
            d = (k - m_owner[m] - 1 + 2 * N) % N;
            if (e[k] && d < bestd) begin
              bestd = d;
              win   = k;
            end
          end
        end
      end
      check("in_ready", m, rdy[m], (win >= 0) ? (1 << win) : 0);
      n_owner[m] = m_owner[m]; n_run[m] = m_run[m]; n_lock[m] = m_lock[m];
      n_ov[m] = m_ov[m]; n_od[m] = m_od[m]; n_oid[m] = m_oid[m];
      if (!arst_ni) begin
        n_owner[m] = N - 1; n_run[m] = 0; n_lock[m] = 0;
        n_ov[m] = 0; n_od[m] = 0; n_oid[m] = 0;
      end else if (ld) begin
        if (win >= 0) begin
          if (m_lock[m] && win == m_owner[m] && m_run[m] < burst_of[m] && e[m_owner[m]])
            n_run[m] = m_run[m] + 1;
          else begin
            n_run[m] = 1; n_owner[m] = win; n_lock[m] = 1;
          end
          n_ov[m] = 1; n_od[m] = int'(elem_in[win*W +: W]); n_oid[m] = win;
          if (m == 0) glog0.push_back(win); else glog1.push_back(win);
        end else begin
          n_ov[m] = 0; n_lock[m] = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = n_owner[m]; m_run[m] = n_run[m]; m_lock[m] = n_lock[m];
      m_ov[m] = n_ov[m]; m_od[m] = n_od[m]; m_oid[m] = n_oid[m];
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < N; k++) elem_in[k*W +: W] = W'(cyc * 3 + k * 5 + 1);
    end
  endtask

  task automatic clear_logs();
    glog0.delete();
    glog1.delete();
  endtask

  task automatic do_reset();
    arst_ni = 1'b0;
    step(1);
    arst_ni = 1'b1;
    clear_logs();
  endtask

  // Grant sequence written as hex nibbles, first grant in the most significant digit.
  task automatic expect_seq(string name, int m, int len, logic [63:0] seq);
    int got;
    for (int i = 0; i < len; i++) begin
      if (m == 0) got = (i < glog0.size()) ? glog0[i] : -1;
      else        got = (i < glog1.size()) ? glog1[i] : -1;
      check(name, m, got, 32'((seq >> (4 * (len - 1 - i))) & 64'hF));
    end
    check({name, "_len"}, m, (m == 0) ? glog0.size() : glog1.size(), len);
  endtask

  initial begin
    arst_ni   = 1'b0;
    req_en    = 4'hF;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    elem_in   = 16'h4321;
    step(3);
    #1;
    for (int m = 0; m < 2; m++) begin
      check("rst_valid", m, ov[m], 0);
      check("rst_data", m, od[m], 0);
      check("rst_id", m, oid[m], 0);
      check("rst_ready", m, rdy[m], 0);
    end

    clear_logs();
    arst_ni = 1'b1;
    step(9);
    expect_seq("rr_seq", 0, 9, 64'h012301230);
    expect_seq("burst_seq", 1, 9, 64'h001122330);

    do_reset();
    step(3);
    in_valid = 4'b1101;
    step(3);
    expect_seq("drop_seq", 0, 6, 64'h012302);
    expect_seq("drop_seq", 1, 6, 64'h001223);
    in_valid = 4'hF;

    do_reset();
    step(2);
    out_ready = 1'b0;
    step(1);
    #1;
    check("stall_id", 0, oid[0], 1);
    check("stall_id", 1, oid[1], 0);
    check("stall_ready", 0, rdy[0], 0);
    check("stall_ready", 1, rdy[1], 0);
    step(4);
    out_ready = 1'b1;
    step(3);
    expect_seq("bp_seq", 0, 5, 64'h01230);
    expect_seq("bp_seq", 1, 5, 64'h00112);

    do_reset();
    in_valid = 4'b0100;
    step(6);
    expect_seq("single_seq", 0, 6, 64'h222222);
    expect_seq("single_seq", 1, 6, 64'h222222);
    in_valid = 4'hF;

    do_reset();
    req_en = 4'b1011;
    step(8);
    expect_seq("mask_seq", 0, 8, 64'h01301301);
    expect_seq("mask_seq", 1, 8, 64'h00113300);
    arst_ni = 1'b0;
    step(1);
    #1;
    check("midrst_valid", 0, ov[0], 0);
    check("midrst_valid", 1, ov[1], 0);
    clear_logs();
    arst_ni = 1'b1;
    step(1);
    expect_seq("after_rst", 0, 1, 64'h0);
    expect_seq("after_rst", 1, 1, 64'h0);
    step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
